// File: rtl/crossing_track_arbiter.sv
// Single-track level-crossing controller: arbitrates west/east approach requests,
// runs a flashing warning before granting, and holds the gate through a clearance interval.
module crossing_track_arbiter #(
  parameter int WARN_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 3,
  parameter int FLASH_DIV    = 2,
  parameter int CW           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic TRW,
  input  logic TRE,
  input  logic EXW,
  input  logic EXE,
  output logic GNT_W,
  output logic GNT_E,
  output logic GATE,
  output logic LIGHT,
  output logic BUSY
);

  typedef enum logic [1:0] {IDLE, WARN, GRANT, CLEAR} state_t;

  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CW-1:0] WARN_LOAD  = CW'(WARN_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_TOP  = FW'(FLASH_DIV - 1);
  localparam logic DIR_W = 1'b0;
  localparam logic DIR_E = 1'b1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic          dir, dir_nx;
  logic          last_dir, last_dir_nx;
  logic          light, light_nx;
  logic          req_any;
  logic          exit_dir;

  // Ties go to the direction that was not served last.
  function automatic logic arbitrate(input logic w, input logic e, input logic last);
    return (w & e) ? ~last : e;
  endfunction

  assign req_any  = TRW | TRE;
  assign exit_dir = (dir == DIR_W) ? EXW : EXE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fcnt     <= '0;
      dir      <= DIR_W;
      last_dir <= DIR_E;
      light    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      fcnt     <= fcnt_nx;
      dir      <= dir_nx;
      last_dir <= last_dir_nx;
      light    <= light_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    fcnt_nx     = fcnt;
    dir_nx      = dir;
    last_dir_nx = last_dir;
    light_nx    = light;

    // Flasher runs continuously while busy, including across CLEAR -> WARN.
    if (state != IDLE) begin
      if (fcnt == FLASH_TOP) begin
        light_nx = ~light;
        fcnt_nx  = '0;
      end else begin
        fcnt_nx = fcnt + FW'(1);
      end
    end

    unique case (state)
      IDLE: begin
        light_nx = 1'b0;
        fcnt_nx  = '0;
        if (req_any) begin
          state_nx = WARN;
          cnt_nx   = WARN_LOAD;
          dir_nx   = arbitrate(TRW, TRE, last_dir);
          light_nx = 1'b1;
        end
      end
      WARN: begin
        if (cnt == '0) state_nx = GRANT;
        else           cnt_nx   = cnt - CW'(1);
      end
      GRANT: begin
        if (exit_dir) begin
          state_nx    = CLEAR;
          cnt_nx      = CLEAR_LOAD;
          last_dir_nx = dir;
        end
      end
      CLEAR: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (req_any) begin
          state_nx = WARN;
          cnt_nx   = WARN_LOAD;
          dir_nx   = arbitrate(TRW, TRE, last_dir);
        end else begin
          state_nx = IDLE;
          light_nx = 1'b0;
          fcnt_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign GATE  = (state != IDLE);
  assign BUSY  = (state != IDLE);
  assign GNT_W = (state == GRANT) && (dir == DIR_W);
  assign GNT_E = (state == GRANT) && (dir == DIR_E);
  assign LIGHT = light;

endmodule

// File: tb/tb_crossing_track_arbiter.sv
// Bench for crossing_track_arbiter: directed scenarios plus random traffic,
// compared each cycle against a behavioural crossing model.
module tb_crossing_track_arbiter;

  localparam int WARN  = 4;
  localparam int CLEAR = 3;
  localparam int FD    = 2;

  logic clk = 1'b0;
  logic reset, TRW, TRE, EXW, EXE;
  logic GNT_W, GNT_E, GATE, LIGHT, BUSY;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy, m_granted, m_srv_e, m_last_e;
  int m_warn_left, m_clear_left, m_age;

  // Safety monitor state
  bit prev_gnt = 1'b0;
  int quiet = 0;

  crossing_track_arbiter #(
    .WARN_CYCLES(WARN), .CLEAR_CYCLES(CLEAR), .FLASH_DIV(FD), .CW(8)
  ) dut (
    .clk(clk), .reset(reset), .TRW(TRW), .TRE(TRE), .EXW(EXW), .EXE(EXE),
    .GNT_W(GNT_W), .GNT_E(GNT_E), .GATE(GATE), .LIGHT(LIGHT), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit choose_e(input bit w, input bit e, input bit last_e);
    return (w && e) ? !last_e : e;
  endfunction

  // One clock edge of the crossing as the rules describe it.
  task automatic model_step(input bit w, input bit e, input bit xw, input bit xe, input bit rst);
    if (rst) begin
      m_busy = 0; m_granted = 0; m_srv_e = 0; m_last_e = 1;
      m_warn_left = 0; m_clear_left = 0; m_age = 0;
    end else if (!m_busy) begin
      if (w || e) begin
        m_busy = 1; m_srv_e = choose_e(w, e, m_last_e);
        m_warn_left = WARN; m_age = 0;
      end
    end else begin
      m_age++;
      if (m_warn_left > 0) begin
        m_warn_left--;
        if (m_warn_left == 0) m_granted = 1;
      end else if (m_granted) begin
        if (m_srv_e ? xe : xw) begin
          m_granted = 0; m_clear_left = CLEAR; m_last_e = m_srv_e;
        end
      end else begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          if (w || e) begin
            m_srv_e = choose_e(w, e, m_last_e); m_warn_left = WARN;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    bit gnt;
    chk("gate",  GATE,  m_busy);
    chk("busy",  BUSY,  m_busy);
    chk("gnt_w", GNT_W, m_granted && !m_srv_e);
    chk("gnt_e", GNT_E, m_granted && m_srv_e);
    chk("light", LIGHT, m_busy && (((m_age / FD) % 2) == 0));
    gnt = GNT_W | GNT_E;
    chk("gnt_exclusive", GNT_W & GNT_E, 1'b0);
    if (gnt) chk("gnt_implies_gate", GATE, 1'b1);
    if (gnt && !prev_gnt) chk("warn_before_grant", quiet >= WARN, 1'b1);
    if (gnt) quiet = 0;
    else if (BUSY) quiet++;
    else quiet = 0;
    prev_gnt = gnt;
  endtask

  task automatic step(input bit w, input bit e, input bit xw, input bit xe, input bit rst);
    TRW = w; TRE = e; EXW = xw; EXE = xe; reset = rst;
    @(posedge clk);
    model_step(w, e, xw, xe, rst);
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; TRW = 1'b0; TRE = 1'b0; EXW = 1'b0; EXE = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_gate", GATE, 1'b0);
    chk("reset_light", LIGHT, 1'b0);

    // Single-cycle west request, released by EXW
    step(1, 0, 0, 0, 0);
    chk("s1_gate_warn", GATE, 1'b1);
    chk("s1_light_first", LIGHT, 1'b1);
    idle_steps(3);
    chk("s1_no_early_grant", GNT_W, 1'b0);
    idle_steps(1);
    chk("s1_grant_w", GNT_W, 1'b1);
    idle_steps(3);
    step(0, 0, 1, 0, 0);
    chk("s1_grant_dropped", GNT_W, 1'b0);
    idle_steps(2);
    chk("s1_gate_held", GATE, 1'b1);
    idle_steps(1);
    chk("s1_gate_open", GATE, 1'b0);
    chk("s1_busy_off", BUSY, 1'b0);

    // Tie after reset goes west; east then served straight from CLEAR
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("s2_tie_w", GNT_W, 1'b1);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("s2_gate_stays", GATE, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("s2_grant_e", GNT_E, 1'b1);
    step(0, 0, 0, 1, 0);
    idle_steps(4);

    // Opposite exit sensor and opposite request don't end a west grant
    step(1, 0, 0, 0, 0);
    idle_steps(4);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("s3_hold_w", GNT_W, 1'b1);
    step(0, 0, 1, 0, 0);
    idle_steps(4);

    // Reset during an east grant, then tie goes west again
    step(0, 1, 0, 0, 0);
    idle_steps(4);
    chk("s5_grant_e", GNT_E, 1'b1);
    step(0, 1, 0, 0, 1);
    chk("s5_reset_gnt", GNT_E, 1'b0);
    chk("s5_reset_gate", GATE, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("s5_tie_w", GNT_W, 1'b1);
    step(0, 0, 1, 0, 0);
    idle_steps(4);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 249) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
